// File: rtl/instr_decode.sv
// Instruction register plus field decoder feeding the CPU control FSM and datapath.
// Optional build macro INSTR_DECODE_LUI_EN turns op 1111 into LUI instead of an illegal encoding.
module instr_decode #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] mem_data,
    output logic [1:0]       instr_type,
    output logic             wb,
    output logic [3:0]       op,
    output logic [3:0]       ext,
    output logic [3:0]       rdest,
    output logic [3:0]       rsrc,
    output logic [WIDTH-1:0] imm,
    output logic             ir_valid,
    output logic             illegal,
    output logic [15:0]      fetch_count
);

    logic [WIDTH-1:0] ir_q, ir_d;
    logic [1:0]       type_q, type_d;
    logic             wb_q, wb_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             ir_valid_q, ir_valid_d;
    logic             illegal_q, illegal_d;
    logic [15:0]      fetch_count_q, fetch_count_d;

    logic [1:0]       dec_type;
    logic             dec_wb;
    logic [WIDTH-1:0] dec_imm;
    logic             dec_illegal;
    logic [3:0]       m_op, m_ext;
    logic [WIDTH-1:0] imm_sext, imm_zext;

    assign m_op     = mem_data[15:12];
    assign m_ext    = mem_data[7:4];
    assign imm_sext = {{(WIDTH-8){mem_data[7]}}, mem_data[7:0]};
    assign imm_zext = {{(WIDTH-8){1'b0}}, mem_data[7:0]};

    // Decode straight from the memory word so every output is loaded on the capture edge.
    // Illegal encodings keep the NOP defaults and only raise dec_illegal.
    always_comb begin
        dec_type    = 2'b00;
        dec_wb      = 1'b0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (m_op)
            4'h0: begin
                case (m_ext)
                    4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hD: dec_wb = 1'b1;
                    4'hB, 4'h0: dec_wb = 1'b0;
                    default: dec_illegal = 1'b1;
                endcase
            end
            4'h4: begin
                case (m_ext)
                    4'h0: dec_type = 2'b10;
                    4'h4: begin
                        dec_type = 2'b10;
                        dec_wb   = 1'b1;
                    end
                    4'h8: begin
                        dec_type = 2'b11;
                        dec_wb   = 1'b1;
                    end
                    4'hC: dec_type = 2'b11;
                    default: dec_illegal = 1'b1;
                endcase
            end
            4'h5, 4'h9, 4'hD: begin
                dec_type = 2'b01;
                dec_wb   = 1'b1;
                dec_imm  = imm_sext;
            end
            4'h1, 4'h2, 4'h3: begin
                dec_type = 2'b01;
                dec_wb   = 1'b1;
                dec_imm  = imm_zext;
            end
            4'hB: begin
                dec_type = 2'b01;
                dec_imm  = imm_sext;
            end
`ifdef INSTR_DECODE_LUI_EN
            4'hF: begin
                dec_type = 2'b01;
                dec_wb   = 1'b1;
                dec_imm  = {mem_data[7:0], {(WIDTH-8){1'b0}}};
            end
`else
            4'hF: dec_illegal = 1'b1;
`endif
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        ir_d          = ir_q;
        type_d        = type_q;
        wb_d          = wb_q;
        imm_d         = imm_q;
        ir_valid_d    = ir_valid_q;
        illegal_d     = illegal_q;
        fetch_count_d = fetch_count_q;
        if (i_en) begin
            ir_d          = mem_data;
            type_d        = dec_type;
            wb_d          = dec_wb;
            imm_d         = dec_imm;
            ir_valid_d    = 1'b1;
            illegal_d     = illegal_q | dec_illegal;
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q          <= '0;
            type_q        <= 2'b00;
            wb_q          <= 1'b0;
            imm_q         <= '0;
            ir_valid_q    <= 1'b0;
            illegal_q     <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            ir_q          <= ir_d;
            type_q        <= type_d;
            wb_q          <= wb_d;
            imm_q         <= imm_d;
            ir_valid_q    <= ir_valid_d;
            illegal_q     <= illegal_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr_type  = type_q;
    assign wb          = wb_q;
    assign op          = ir_q[15:12];
    assign ext         = ir_q[7:4];
    assign rdest       = ir_q[11:8];
    assign rsrc        = ir_q[3:0];
    assign imm         = imm_q;
    assign ir_valid    = ir_valid_q;
    assign illegal     = illegal_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed-vector bench for instr_decode; expected values are hand-computed from the encoding table.
module tb_instr_decode;

    logic        clk;
    logic        reset;
    logic        i_en;
    logic [15:0] mem_data;
    logic [1:0]  instr_type;
    logic        wb;
    logic [3:0]  op, ext, rdest, rsrc;
    logic [15:0] imm;
    logic        ir_valid, illegal;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_decode #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (i_en),
        .mem_data   (mem_data),
        .instr_type (instr_type),
        .wb         (wb),
        .op         (op),
        .ext        (ext),
        .rdest      (rdest),
        .rsrc       (rsrc),
        .imm        (imm),
        .ir_valid   (ir_valid),
        .illegal    (illegal),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle fetch strobe; returns at the following negedge with outputs settled.
    task automatic fetch(input logic [15:0] w);
        @(negedge clk);
        mem_data = w;
        i_en     = 1'b1;
        @(negedge clk);
        i_en     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_dec(input string tag, input logic [1:0] t, input logic w, input logic [15:0] im);
        chk({tag, "_type"}, instr_type, t);
        chk({tag, "_wb"},   wb, w);
        chk({tag, "_imm"},  imm, im);
    endtask

    initial begin
        reset    = 1'b1;
        i_en     = 1'b0;
        mem_data = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        chk_dec("rst", 2'b00, 1'b0, 16'h0000);
        chk("rst_op", {op, ext, rdest, rsrc}, 16'h0000);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_count", fetch_count, 16'd0);

        fetch(16'h0351);
        chk_dec("add", 2'b00, 1'b1, 16'h0000);
        chk("add_rdest", rdest, 4'd3);
        chk("add_rsrc", rsrc, 4'd1);
        chk("add_ext", ext, 4'd5);
        chk("add_op", op, 4'd0);
        chk("add_valid", ir_valid, 1'b1);
        chk("add_count", fetch_count, 16'd1);

        fetch(16'h52F0);
        chk_dec("addi", 2'b01, 1'b1, 16'hFFF0);
        chk("addi_op", op, 4'd5);
        fetch(16'h12F0);
        chk_dec("andi", 2'b01, 1'b1, 16'h00F0);
        fetch(16'h4402);
        chk_dec("load", 2'b10, 1'b0, 16'h0000);
        fetch(16'h4442);
        chk_dec("stor", 2'b10, 1'b1, 16'h0000);
        fetch(16'h4E85);
        chk_dec("jal", 2'b11, 1'b1, 16'h0000);
        chk("jal_rdest", rdest, 4'hE);
        fetch(16'h40C5);
        chk_dec("jcond", 2'b11, 1'b0, 16'h0000);
        fetch(16'hB3FF);
        chk_dec("cmpi", 2'b01, 1'b0, 16'hFFFF);
        fetch(16'h03B1);
        chk_dec("cmp", 2'b00, 1'b0, 16'h0000);
        chk("legal_noflag", illegal, 1'b0);
        chk("count9", fetch_count, 16'd9);

        // i_en low: everything holds even though mem_data changes
        @(negedge clk);
        mem_data = 16'h52F0;
        repeat (3) @(negedge clk);
        chk("hold_ir", {op, ext, rdest, rsrc}, 16'h0B31);
        chk_dec("hold", 2'b00, 1'b0, 16'h0000);
        chk("hold_count", fetch_count, 16'd9);

        fetch(16'hF2AB);
`ifdef INSTR_DECODE_LUI_EN
        chk_dec("lui", 2'b01, 1'b1, 16'hAB00);
        chk("lui_illegal", illegal, 1'b0);
`else
        chk_dec("f_op", 2'b00, 1'b0, 16'h0000);
        chk("f_illegal", illegal, 1'b1);
        chk("f_rdest", rdest, 4'h2);
        fetch(16'h0351);
        chk_dec("add2", 2'b00, 1'b1, 16'h0000);
        chk("sticky", illegal, 1'b1);
`endif

        do_reset();
        chk("rst2_illegal", illegal, 1'b0);
        fetch(16'h0071);
        chk_dec("bad_ext", 2'b00, 1'b0, 16'h0000);
        chk("bad_ext_flag", illegal, 1'b1);
        chk("bad_ext_raw", ext, 4'h7);
        fetch(16'h4412);
        chk("bad_ext4_raw", rsrc, 4'h2);
        chk_dec("bad_ext4", 2'b00, 1'b0, 16'h0000);

        // async reset between edges with i_en high
        @(negedge clk);
        mem_data = 16'h52F0;
        i_en     = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_count", fetch_count, 16'd0);
        chk("async_valid", ir_valid, 1'b0);
        chk("async_ir", {op, ext, rdest, rsrc}, 16'h0000);
        chk("async_illegal", illegal, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_nocap_count", fetch_count, 16'd0);
        chk("rst_nocap_type", instr_type, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        i_en = 1'b0;
        chk_dec("post_rst", 2'b01, 1'b1, 16'hFFF0);
        chk("post_rst_count", fetch_count, 16'd1);

        // wrap: 65535 back-to-back captures then one more
        do_reset();
        @(negedge clk);
        mem_data = 16'h0351;
        i_en     = 1'b1;
        repeat (65535) @(negedge clk);
        i_en = 1'b0;
        chk("count_ffff", fetch_count, 16'hFFFF);
        fetch(16'h4442);
        chk("count_wrap", fetch_count, 16'h0000);
        chk_dec("wrap_stor", 2'b10, 1'b1, 16'h0000);
        chk("wrap_valid", ir_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction register and decoder sitting between instruction memory and the CPU control FSM. When `i_en` is high it captures the memory data word and registers the decoded fields on the same edge. The FSM's `type`/`wb` inputs and the datapath's register addresses, immediate and ALU op come from here. It also keeps a sticky illegal-opcode flag and a fetch counter for debug.

## Interface
- `WIDTH`, default 16: instruction/data word width; only 16 is supported.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all registers immediately.
- `i_en` input 1: fetch strobe from the FSM; captures `mem_data` at the next rising edge.
- `mem_data` input WIDTH: instruction word from memory port.
- `type` output 2: instruction class, 00 rType, 01 iType, 10 pType, 11 jType.
- `wb` output 1: writeback qualifier consumed by the FSM.
- `op` output 4: IR[15:12].
- `ext` output 4: IR[7:4], the op extension / condition field.
- `rdest` output 4: IR[11:8].
- `rsrc` output 4: IR[3:0].
- `imm` output WIDTH: extended immediate.
- `ir_valid` output 1: high once any instruction has been captured.
- `illegal` output 1: sticky flag, set by an undefined encoding.
- `fetch_count` output 16: number of captures, wraps.

## Operation
- IR and all decoded outputs are registers, loaded together when `i_en`=1. With `i_en`=0 all are held.
- Decode uses `op`=IR[15:12] and `ext`=IR[7:4].
- **op 0000 (register-register):**
  - ext 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV give type=00, wb=1.
  - ext 1011 CMP gives type=00, wb=0.
  - ext 0000 NOP gives type=00, wb=0.
  - Any other ext is illegal.
- **op 0100 (memory and jump):**
  - ext 0000 LOAD gives type=10, wb=0.
  - ext 0100 STOR gives type=10, wb=1.
  - ext 1000 JAL gives type=11, wb=1.
  - ext 1100 Jcond gives type=11, wb=0.
  - Any other ext is illegal.
- **Immediate ops:**
  - op 0101 ADDI, 1001 SUBI, 1101 MOVI, 0001 ANDI, 0010 ORI, 0011 XORI give type=01, wb=1.
  - op 1011 CMPI gives type=01, wb=0.
- **imm:**
  - Sign-extended IR[7:0] for ADDI/SUBI/CMPI/MOVI.
  - Zero-extended IR[7:0] for ANDI/ORI/XORI.
  - 0 for all other instructions.
- **Illegal encodings:**
  - Decode as NOP: type=00, wb=0, imm=0.
  - Raw fields `op`/`ext`/`rdest`/`rsrc` still reflect IR.
  - `illegal` is set and stays set until reset.
- `ir_valid` goes to 1 on the first capture and stays 1 until reset.
- `fetch_count` increments by 1 per capture, wrapping mod 2^16 (FFFF goes to 0000).
- `i_en` held high for N cycles performs N captures; the last word wins and the count rises by N.

## Timing
- Latency is 1 cycle: `mem_data` sampled at the edge ending an `i_en`=1 cycle is decoded and visible in the next cycle. This matches FSM fetch state S0 feeding decode state S1.
- Outputs are purely registered; there is no combinational path from `mem_data` or `i_en` to any output.
- **Reset values:** IR=0, type=00, wb=0, op/ext/rdest/rsrc=0, imm=0, ir_valid=0, illegal=0, fetch_count=0.
- Reset asserted mid-operation clears all state asynchronously, without waiting for an edge.
- `reset` overrides `i_en` in the same cycle; no capture occurs while reset is high.
- The first `i_en` edge after deassertion captures normally.

## Configuration
- Macro `INSTR_DECODE_LUI_EN`.
- **Defined:** op 1111 is LUI: type=01, wb=1, imm={IR[7:0], 8'h00}, not illegal.
- **Undefined:** op 1111 is illegal; it decodes as NOP and sets `illegal`.

## Test plan
- Reset, then no `i_en` → all outputs 0, `ir_valid`=0.
- `mem_data`=16'h0351 (ADD r3,r1) with `i_en` one cycle → next cycle type=00, wb=1, rdest=3, rsrc=1, ext=5, ir_valid=1, fetch_count=1.
- ADDI 16'h52F0 → type=01, wb=1, imm=16'hFFF0.
- ANDI 16'h12F0 → imm=16'h00F0.
- LOAD 16'h4402 → type=10, wb=0.
- STOR 16'h4442 → type=10, wb=1.
- JAL 16'h4E85 → type=11, wb=1.
- Jcond 16'h40C5 → type=11, wb=0.
- 16'hF2AB:
  - Macro undefined → type=00, wb=0, illegal=1; illegal stays 1 after a following legal ADD.
  - Macro defined → type=01, wb=1, imm=16'hAB00, illegal=0.
- Preload count to FFFF (65535 captures), capture once more → fetch_count=0000.
- Assert `reset` between clock edges while `i_en`=1 → outputs clear immediately; no capture at the following edge.
